// File: rtl/vga_timing_gen.sv
// Raster timing generator: parametrised porches/sync/polarity, pixel-clock prescaler, event pulses.
// Latency: all outputs registered; x/y/decode/pulses update in the clk where pix_en is high.
// Backpressure: none; en=0 freezes prescaler, counters and decode, and forces strobes low.
// Optional frame counter output frame_cnt enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] presc;
    logic          tick;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;

    // Next raster position, computed once so decode and pulses align with the counters
    always_comb begin
        tick   = en && (presc == PRESC_LAST);
        x_next = (x == H_LAST) ? '0 : x + CW'(1);
        y_next = y;
        if (x == H_LAST) begin
            y_next = (y == V_LAST) ? '0 : y + CW'(1);
        end
    end

    // Prescaler, counters, registered decode and event strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            presc        <= '0;
            x            <= '0;
            y            <= '0;
            pix_en       <= 1'b0;
            blank        <= 1'b0;
            hs           <= ~HS_POL;
            vs           <= ~VS_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt    <= 16'd0;
`endif
        end else begin
            pix_en       <= tick;
            line_start   <= tick && (x_next == '0);
            frame_start  <= tick && (x_next == '0) && (y_next == '0);
            vblank_start <= tick && (x_next == '0) && (y_next == V_ACT);
            if (en) begin
                presc <= tick ? '0 : presc + PW'(1);
            end
            if (tick) begin
                x     <= x_next;
                y     <= y_next;
                blank <= (x_next >= H_ACT) || (y_next >= V_ACT);
                hs    <= ((x_next >= HS_BEG) && (x_next < HS_END)) ? HS_POL : ~HS_POL;
                vs    <= ((y_next >= VS_BEG) && (y_next < VS_END)) ? VS_POL : ~VS_POL;
`ifdef VGA_FRAME_CNT_EN
                if ((x_next == '0) && (y_next == '0)) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets driven by shared random reset/en.
// Expected outputs derived from the count of enabled clocks since reset.
// Defaults instance covers the first lines; two small configs cover full frames.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic en    = 1'b0;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       ls;
        logic       fs;
        logic       vbs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, d;
        bit hp, vp;
    } cfg_t;

    logic       a_pix_en, a_hs, a_vs, a_blank, a_ls, a_fs, a_vbs;
    logic [9:0] a_x, a_y;
    logic       b_pix_en, b_hs, b_vs, b_blank, b_ls, b_fs, b_vbs;
    logic [9:0] b_x, b_y;
    logic       c_pix_en, c_hs, c_vs, c_blank, c_ls, c_fs, c_vbs;
    logic [9:0] c_x, c_y;
    logic [15:0] a_fc = 16'd0;
    logic [15:0] b_fc = 16'd0;
    logic [15:0] c_fc = 16'd0;

    vga_timing_gen u_a (
        .clk(clk), .reset(reset), .en(en), .pix_en(a_pix_en), .x(a_x), .y(a_y),
        .hs(a_hs), .vs(a_vs), .blank(a_blank), .line_start(a_ls),
        .frame_start(a_fs), .vblank_start(a_vbs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
    ) u_b (
        .clk(clk), .reset(reset), .en(en), .pix_en(b_pix_en), .x(b_x), .y(b_y),
        .hs(b_hs), .vs(b_vs), .blank(b_blank), .line_start(b_ls),
        .frame_start(b_fs), .vblank_start(b_vbs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .CW(10)
    ) u_c (
        .clk(clk), .reset(reset), .en(en), .pix_en(c_pix_en), .x(c_x), .y(c_y),
        .hs(c_hs), .vs(c_vs), .blank(c_blank), .line_start(c_ls),
        .frame_start(c_fs), .vblank_start(c_vbs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(c_fc)
`endif
    );

    int     n_assert = 0;
    int     n_fail   = 0;
    longint k        = 0;   // enabled clk edges since the last reset
    bit     last_en  = 1'b0; // previous edge was an enabled, non-reset edge
    cfg_t   ca, cb, cc;
    int     hs_cnt, blank_cnt;

    // Expected outputs: pixel index = enabled clocks / divider; position from div/mod
    function automatic obs_t model(input cfg_t c);
        obs_t   o;
        longint ht, vt, p, xi, yi;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        p  = k / c.d;
        xi = p % ht;
        yi = (p / ht) % vt;
        o.pix_en = last_en && ((k % c.d) == 0);
        o.x      = 10'(xi);
        o.y      = 10'(yi);
        o.hs     = (xi >= c.ha + c.hf && xi < c.ha + c.hf + c.hsw) ? c.hp : !c.hp;
        o.vs     = (yi >= c.va + c.vf && yi < c.va + c.vf + c.vsw) ? c.vp : !c.vp;
        o.blank  = (xi >= c.ha) || (yi >= c.va);
        o.ls     = o.pix_en && (xi == 0);
        o.fs     = o.pix_en && (xi == 0) && (yi == 0);
        o.vbs    = o.pix_en && (xi == 0) && (yi == c.va);
`ifdef VGA_FRAME_CNT_EN
        o.fc     = 16'(p / (ht * vt));
`else
        o.fc     = 16'd0;
`endif
        return o;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic chk_inst(input string nm, input obs_t got, input obs_t exp);
        chk({nm, "_pix_en"}, 16'(got.pix_en), 16'(exp.pix_en));
        chk({nm, "_x"}, 16'(got.x), 16'(exp.x));
        chk({nm, "_y"}, 16'(got.y), 16'(exp.y));
        chk({nm, "_hs"}, 16'(got.hs), 16'(exp.hs));
        chk({nm, "_vs"}, 16'(got.vs), 16'(exp.vs));
        chk({nm, "_blank"}, 16'(got.blank), 16'(exp.blank));
        chk({nm, "_line_start"}, 16'(got.ls), 16'(exp.ls));
        chk({nm, "_frame_start"}, 16'(got.fs), 16'(exp.fs));
        chk({nm, "_vblank_start"}, 16'(got.vbs), 16'(exp.vbs));
`ifdef VGA_FRAME_CNT_EN
        chk({nm, "_frame_cnt"}, got.fc, exp.fc);
`endif
    endtask

    task automatic check_all();
        chk_inst("a", '{a_pix_en, a_x, a_y, a_hs, a_vs, a_blank, a_ls, a_fs, a_vbs, a_fc}, model(ca));
        chk_inst("b", '{b_pix_en, b_x, b_y, b_hs, b_vs, b_blank, b_ls, b_fs, b_vbs, b_fc}, model(cb));
        chk_inst("c", '{c_pix_en, c_x, c_y, c_hs, c_vs, c_blank, c_ls, c_fs, c_vbs, c_fc}, model(cc));
    endtask

    // One clk: drive inputs after the falling edge, advance the model at the rising edge, check at the next falling edge
    task automatic step(input bit r, input bit e);
        reset = r;
        en    = e;
        @(posedge clk);
        if (r) begin
            k       = 0;
            last_en = 1'b0;
        end else if (e) begin
            k++;
            last_en = 1'b1;
        end else begin
            last_en = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        ca = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
        cb = '{4, 1, 1, 1, 2, 1, 1, 1, 1, 1'b1, 1'b1};
        cc = '{8, 2, 3, 2, 5, 1, 2, 2, 3, 1'b0, 1'b1};
        @(negedge clk);

        // Reset held: reset values, no strobes
        repeat (3) step(1'b1, 1'b0);

        // Continuous run: defaults instance crosses into line 2, small configs run many frames
        hs_cnt    = 0;
        blank_cnt = 0;
        repeat (3400) begin
            step(1'b0, 1'b1);
            if (a_y == 10'd0 && a_hs == 1'b0) hs_cnt++;
            if (a_y == 10'd0 && a_blank == 1'b1) blank_cnt++;
        end
        chk("a_hs_clks_line0", 16'(hs_cnt), 16'd192);
        chk("a_blank_clks_line0", 16'(blank_cnt), 16'd320);

        // Random freezes: positions and prescaler phase must hold across en=0
        repeat (3000) step(1'b0, $urandom_range(0, 3) != 0);

        // Reset mid-frame with en high: reset wins
        step(1'b1, 1'b1);
        repeat (2000) step(1'b0, $urandom_range(0, 7) != 0);

        // Mixed random reset and en
        repeat (1500) step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
